// File: rtl/env_pkg.sv
// -----------------------------------------------------------------------------
// env_pkg
// Shared definitions for the envelope detector: FSM state encoding, default
// parameter values and helpers that derive the internal widths from the
// module parameters.
// -----------------------------------------------------------------------------
package env_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2
    } env_state_t;

    localparam int DEF_IN_WIDTH         = 20;
    localparam int DEF_LOG2_WIN         = 4;
    localparam int DEF_DECIM            = 4;
    localparam int DEF_SAMPLES_PER_LINE = 1024;

    // Running sum must hold 2^LOG2_WIN full-scale magnitudes.
    function automatic int env_sum_width(input int in_width, input int log2_win);
        return in_width + log2_win;
    endfunction

    function automatic int env_ptr_width(input int log2_win);
        return log2_win;
    endfunction

    // Line counter has to reach SAMPLES_PER_LINE itself.
    function automatic int env_cnt_width(input int spl);
        return $clog2(spl + 1);
    endfunction

    // Phase counter spans 0..DECIM-1; keep at least one bit for DECIM=1.
    function automatic int env_phase_width(input int decim);
        return (decim > 1) ? $clog2(decim) : 1;
    endfunction

endpackage

// File: rtl/env_window_sum.sv
// -----------------------------------------------------------------------------
// env_window_sum
// Circular buffer of the last 2^LOG2_WIN magnitudes plus a running sum.
// o_new_sum is the sum including the magnitude currently on i_mag; it is
// committed to the running sum (and i_mag to the buffer) when i_wr_en is high.
//
// Ports
//   clk        clock
//   reset      synchronous active-high reset
//   i_clear    synchronous clear of buffer, pointer and sum (line restart)
//   i_wr_en    write i_mag into the window this cycle
//   i_mag      unsigned magnitude, IN_WIDTH bits
//   o_new_sum  sum + i_mag - oldest entry, SUM_WIDTH bits (combinational)
// -----------------------------------------------------------------------------
module env_window_sum
    import env_pkg::*;
#(
    parameter int IN_WIDTH = DEF_IN_WIDTH,
    parameter int LOG2_WIN = DEF_LOG2_WIN
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          i_clear,
    input  logic                                          i_wr_en,
    input  logic [IN_WIDTH-1:0]                           i_mag,
    output logic [env_sum_width(IN_WIDTH, LOG2_WIN)-1:0]  o_new_sum
);

    localparam int DEPTH     = 1 << LOG2_WIN;
    localparam int SUM_WIDTH = env_sum_width(IN_WIDTH, LOG2_WIN);
    localparam int PTR_WIDTH = env_ptr_width(LOG2_WIN);

    logic [PTR_WIDTH-1:0] r_wr_ptr;
    logic [SUM_WIDTH-1:0] r_sum;
    logic [IN_WIDTH-1:0]  w_buf [DEPTH];
    logic [IN_WIDTH-1:0]  w_old;

    // One register per slot; the slot addressed by the write pointer is the
    // oldest sample and gets overwritten by the new one.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic [IN_WIDTH-1:0] r_slot;

            always_ff @(posedge clk) begin
                if (reset || i_clear) begin
                    r_slot <= '0;
                end else if (i_wr_en && (r_wr_ptr == PTR_WIDTH'(gi))) begin
                    r_slot <= i_mag;
                end
            end

            assign w_buf[gi] = r_slot;
        end
    endgenerate

    // While the window is filling the slots read back as zero, so the
    // subtraction below is harmless.
    assign w_old     = w_buf[r_wr_ptr];
    assign o_new_sum = r_sum + SUM_WIDTH'(i_mag) - SUM_WIDTH'(w_old);

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_wr_ptr <= '0;
            r_sum    <= '0;
        end else if (i_wr_en) begin
            r_wr_ptr <= r_wr_ptr + PTR_WIDTH'(1);
            r_sum    <= o_new_sum;
        end
    end

endmodule

// File: rtl/envelope_detector.sv
// -----------------------------------------------------------------------------
// envelope_detector
// Rectifies each accepted beamformed sample, averages it over a boxcar window
// of 2^LOG2_WIN samples and emits every DECIM-th average (plus the final one of
// the line) two cycles after the sample was presented.
//
// Ports
//   clk        clock
//   reset      synchronous active-high reset
//   start      pulse: begin (or restart) a scan line
//   in_valid   in_sample valid this cycle (no backpressure)
//   in_sample  signed beamformed sample, IN_WIDTH bits
//   env_valid  env_out valid this cycle (single-cycle pulse)
//   env_out    unsigned envelope value, IN_WIDTH bits (holds between outputs)
//   env_last   final output of the line, coincident with env_valid
//   busy       line in progress (FILL or RUN)
// -----------------------------------------------------------------------------
module envelope_detector
    import env_pkg::*;
#(
    parameter int IN_WIDTH         = DEF_IN_WIDTH,
    parameter int LOG2_WIN         = DEF_LOG2_WIN,
    parameter int DECIM            = DEF_DECIM,
    parameter int SAMPLES_PER_LINE = DEF_SAMPLES_PER_LINE
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       in_valid,
    input  logic signed [IN_WIDTH-1:0] in_sample,
    output logic                       env_valid,
    output logic [IN_WIDTH-1:0]        env_out,
    output logic                       env_last,
    output logic                       busy
);

    localparam int WIN       = 1 << LOG2_WIN;
    localparam int SUM_WIDTH = env_sum_width(IN_WIDTH, LOG2_WIN);
    localparam int CNT_W     = env_cnt_width(SAMPLES_PER_LINE);
    localparam int PH_W      = env_phase_width(DECIM);

    env_state_t          r_state;
    env_state_t          w_state_next;
    logic [CNT_W-1:0]    r_line_cnt;
    logic [PH_W-1:0]     r_phase;

    logic [IN_WIDTH-1:0] r_mag;
    logic                r_mag_vld;
    logic                r_mag_emit;
    logic                r_mag_last;

    logic                r_env_valid;
    logic                r_env_last;
    logic [IN_WIDTH-1:0] r_env_out;

    logic                w_accept;
    logic                w_idx_last;
    logic                w_run_update;
    logic                w_phase_zero;
    logic [IN_WIDTH-1:0] w_mag;
    logic                w_wr_en;
    logic [SUM_WIDTH-1:0] w_new_sum;

    // A start in the same cycle wins over the sample.
    assign w_accept     = in_valid && !start && (r_state != ST_IDLE);
    assign w_idx_last   = (r_line_cnt == CNT_W'(SAMPLES_PER_LINE - 1));
    // Samples from index WIN-1 onwards complete a full window (RUN updates).
    assign w_run_update = (r_line_cnt >= CNT_W'(WIN - 1));
    assign w_phase_zero = (r_phase == '0);

    // Two's-complement negate; the most negative value lands exactly on
    // 2^(IN_WIDTH-1) once reinterpreted as unsigned.
    assign w_mag = in_sample[IN_WIDTH-1] ? $unsigned(-in_sample) : $unsigned(in_sample);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_next = ST_FILL;
            end
            ST_FILL: begin
                if (start) begin
                    w_state_next = ST_FILL;
                end else if (w_accept && (r_line_cnt == CNT_W'(WIN - 1))) begin
                    // A line no longer than one window ends on the same sample.
                    w_state_next = w_idx_last ? ST_IDLE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (start) begin
                    w_state_next = ST_FILL;
                end else if (w_accept && w_idx_last) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------- line and decimation counters
    always_ff @(posedge clk) begin
        if (reset || start) begin
            r_line_cnt <= '0;
            r_phase    <= '0;
        end else if (w_accept) begin
            r_line_cnt <= r_line_cnt + CNT_W'(1);
            if (w_run_update) begin
                r_phase <= (r_phase == PH_W'(DECIM - 1)) ? '0 : r_phase + PH_W'(1);
            end
        end
    end

    // ----------------------------------------------------- stage 1: rectify
    // Emit/last decisions are taken here, alongside the sample they belong to,
    // so stage 2 only has to qualify them with the window write.
    always_ff @(posedge clk) begin
        if (reset || start) begin
            r_mag      <= '0;
            r_mag_vld  <= 1'b0;
            r_mag_emit <= 1'b0;
            r_mag_last <= 1'b0;
        end else begin
            r_mag_vld  <= w_accept;
            r_mag_emit <= w_accept && w_run_update && (w_phase_zero || w_idx_last);
            r_mag_last <= w_accept && w_idx_last;
            if (w_accept) begin
                r_mag <= w_mag;
            end
        end
    end

    // ---------------------------------------------- stage 2: window + output
    // A start discards the magnitude still in stage 1.
    assign w_wr_en = r_mag_vld && !start;

    env_window_sum #(
        .IN_WIDTH (IN_WIDTH),
        .LOG2_WIN (LOG2_WIN)
    ) u_window (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (start),
        .i_wr_en   (w_wr_en),
        .i_mag     (r_mag),
        .o_new_sum (w_new_sum)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_env_valid <= 1'b0;
            r_env_last  <= 1'b0;
            r_env_out   <= '0;
        end else begin
            r_env_valid <= w_wr_en && r_mag_emit;
            r_env_last  <= w_wr_en && r_mag_last;
            if (w_wr_en && r_mag_emit) begin
                // Average of WIN magnitudes never exceeds IN_WIDTH bits.
                r_env_out <= IN_WIDTH'(w_new_sum >> LOG2_WIN);
            end
        end
    end

    assign env_valid = r_env_valid;
    assign env_last  = r_env_last;
    assign env_out   = r_env_out;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_envelope_detector.sv
// -----------------------------------------------------------------------------
// tb_envelope_detector
// Three detector instances share one stimulus stream:
//   inst 0: LOG2_WIN=2, DECIM=1, SAMPLES_PER_LINE=8
//   inst 1: LOG2_WIN=2, DECIM=4, SAMPLES_PER_LINE=16
//   inst 2: LOG2_WIN=2, DECIM=4, SAMPLES_PER_LINE=14
// A sample-history model predicts every output; a negedge process compares all
// outputs every cycle, and directed scenarios add hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_envelope_detector;

    localparam int IW  = 20;
    localparam int NI  = 3;
    localparam int L2W = 2;
    localparam int WIN = 4;

    function automatic int cfg_dec(input int i);
        return (i == 0) ? 1 : 4;
    endfunction

    function automatic int cfg_spl(input int i);
        return (i == 0) ? 8 : ((i == 1) ? 16 : 14);
    endfunction

    logic                 clk       = 1'b0;
    logic                 reset     = 1'b1;
    logic                 start     = 1'b0;
    logic                 in_valid  = 1'b0;
    logic signed [IW-1:0] in_sample = '0;

    logic          dv    [NI];
    logic          dl    [NI];
    logic          dbusy [NI];
    logic [IW-1:0] dout  [NI];

    generate
        for (genvar gi = 0; gi < NI; gi++) begin : g_dut
            envelope_detector #(
                .IN_WIDTH         (IW),
                .LOG2_WIN         (L2W),
                .DECIM            (cfg_dec(gi)),
                .SAMPLES_PER_LINE (cfg_spl(gi))
            ) u_dut (
                .clk       (clk),
                .reset     (reset),
                .start     (start),
                .in_valid  (in_valid),
                .in_sample (in_sample),
                .env_valid (dv[gi]),
                .env_out   (dout[gi]),
                .env_last  (dl[gi]),
                .busy      (dbusy[gi])
            );
        end
    endgenerate

    always #5 clk = ~clk;

    // ------------------------------------------------------------ counters
    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string nm, input int inst, input logic [63:0] got, input logic [63:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s inst=%0d cyc=%0d got=%0d want=%0d", nm, inst, cyc, got, want);
        end
    endtask

    // --------------------------------------------------------------- model
    typedef struct {
        int     key;
        int     inst;
        longint val;
        bit     last;
    } exp_t;

    typedef struct {
        int     inst;
        int     cyc_no;
        longint val;
        bit     last;
    } cap_t;

    exp_t   pend[$];
    cap_t   cap[$];
    int     cyc  = 0;
    bit     live = 1'b0;
    bit     m_act [NI];
    int     m_cnt [NI];
    longint m_mag [NI][64];
    bit     e_valid [NI];
    bit     e_last  [NI];
    bit     e_busy  [NI];
    longint e_out   [NI];

    // Edge-by-edge model: an accepted sample with index >= WIN-1 produces the
    // mean of the last WIN magnitudes, visible after the following edge, when
    // (idx-(WIN-1)) is a multiple of DECIM or it is the last sample of the line.
    initial forever begin
        @(posedge clk);
        cyc++;
        if (reset) begin
            live = 1'b1;
            pend.delete();
            for (int i = 0; i < NI; i++) begin
                m_act[i]   = 1'b0;
                m_cnt[i]   = 0;
                e_valid[i] = 1'b0;
                e_last[i]  = 1'b0;
                e_busy[i]  = 1'b0;
                e_out[i]   = 0;
            end
        end else begin
            for (int i = 0; i < NI; i++) begin
                e_valid[i] = 1'b0;
                e_last[i]  = 1'b0;
                if (start) begin
                    for (int k = pend.size() - 1; k >= 0; k--)
                        if (pend[k].inst == i) pend.delete(k);
                    m_act[i] = 1'b1;
                    m_cnt[i] = 0;
                end else begin
                    for (int k = pend.size() - 1; k >= 0; k--) begin
                        if (pend[k].inst == i && pend[k].key == cyc) begin
                            e_valid[i] = 1'b1;
                            e_last[i]  = pend[k].last;
                            e_out[i]   = pend[k].val;
                            pend.delete(k);
                        end
                    end
                    if (in_valid && m_act[i]) begin
                        int     idx;
                        longint x;
                        idx = m_cnt[i];
                        x   = longint'(in_sample);
                        m_mag[i][idx] = (x < 0) ? -x : x;
                        m_cnt[i]++;
                        if (idx >= WIN - 1) begin
                            if (((idx - (WIN - 1)) % cfg_dec(i) == 0) || (idx == cfg_spl(i) - 1)) begin
                                longint s;
                                s = 0;
                                for (int j = idx - WIN + 1; j <= idx; j++) s += m_mag[i][j];
                                pend.push_back('{cyc + 1, i, s >> L2W, (idx == cfg_spl(i) - 1)});
                            end
                        end
                        if (m_cnt[i] == cfg_spl(i)) m_act[i] = 1'b0;
                    end
                end
                e_busy[i] = m_act[i];
            end
        end
    end

    // ------------------------------------------------------ compare process
    initial forever begin
        @(negedge clk);
        if (live) begin
            for (int i = 0; i < NI; i++) begin
                chk("env_valid", i, 64'(dv[i]), 64'(e_valid[i]));
                chk("env_last", i, 64'(dl[i]), 64'(e_last[i]));
                chk("busy", i, 64'(dbusy[i]), 64'(e_busy[i]));
                chk("env_out", i, 64'(dout[i]), 64'(e_out[i]));
                if (dv[i] === 1'b1) cap.push_back('{i, cyc, longint'(dout[i]), dl[i]});
            end
        end
    end

    // ------------------------------------------------------- capture helpers
    function automatic int cap_at(input int inst, input int base, input int k);
        int seen;
        seen = 0;
        for (int j = base; j < cap.size(); j++) begin
            if (cap[j].inst == inst) begin
                if (seen == k) return j;
                seen++;
            end
        end
        return -1;
    endfunction

    function automatic int cap_n(input int inst, input int base);
        int n;
        n = 0;
        for (int j = base; j < cap.size(); j++)
            if (cap[j].inst == inst) n++;
        return n;
    endfunction

    task automatic lit(input string nm, input int inst, input int base, input int k,
                       input longint want, input bit want_last);
        int j;
        j = cap_at(inst, base, k);
        if (j < 0) begin
            n_total++;
            n_bad++;
            $display("FAIL %s inst=%0d output #%0d missing want=%0d", nm, inst, k, want);
        end else begin
            chk(nm, inst, 64'(cap[j].val), 64'(want));
            chk({nm, "_last"}, inst, 64'(cap[j].last), 64'(want_last));
        end
    endtask

    // ------------------------------------------------------ stimulus helpers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int v);
        in_valid  = 1'b1;
        in_sample = v[IW-1:0];
        tick();
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic do_start();
        start    = 1'b1;
        in_valid = 1'b0;
        tick();
        start    = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------ scenarios
    initial begin : stim
        int base;
        int s_edge;
        int a3;
        int j0;
        int j1;
        int j3;
        int t1_vals [8];
        t1_vals = '{4, -4, 8, -8, 0, 0, 0, 0};

        reset = 1'b1;
        repeat (3) tick();
        chk("rst_busy", 0, 64'(dbusy[0]), 64'd0);
        chk("rst_valid", 0, 64'(dv[0]), 64'd0);
        chk("rst_out", 0, 64'(dout[0]), 64'd0);
        reset = 1'b0;
        idle(2);

        // Rectify/average: window sums 24,20,16,8,0 -> 6,5,4,2,0.
        base = cap.size();
        do_start();
        for (int k = 0; k < 8; k++) send(t1_vals[k]);
        idle(4);
        chk("t1_count", 0, 64'(cap_n(0, base)), 64'd5);
        lit("t1_avg0", 0, base, 0, 6, 1'b0);
        lit("t1_avg1", 0, base, 1, 5, 1'b0);
        lit("t1_avg2", 0, base, 2, 4, 1'b0);
        lit("t1_avg3", 0, base, 3, 2, 1'b0);
        lit("t1_avg4", 0, base, 4, 0, 1'b1);
        chk("t1_dec_count", 1, 64'(cap_n(1, base)), 64'd2);
        lit("t1_dec0", 1, base, 0, 6, 1'b0);
        lit("t1_dec1", 1, base, 1, 0, 1'b0);

        // Most negative input rectifies to 2^19 without wrapping.
        base = cap.size();
        do_start();
        repeat (8) send(-524288);
        idle(4);
        lit("t2_negmax0", 0, base, 0, 524288, 1'b0);
        lit("t2_negmax4", 0, base, 4, 524288, 1'b1);
        lit("t2_negmax_dec", 1, base, 0, 524288, 1'b0);

        // Decimation: SPL=16 -> idx 3,7,11,15; SPL=14 -> idx 3,7,11, forced 13.
        base = cap.size();
        do_start();
        repeat (16) send(100);
        idle(4);
        chk("t3_count16", 1, 64'(cap_n(1, base)), 64'd4);
        chk("t3_count14", 2, 64'(cap_n(2, base)), 64'd4);
        chk("t3_count8", 0, 64'(cap_n(0, base)), 64'd5);
        for (int k = 0; k < 4; k++) begin
            lit("t3_dec16", 1, base, k, 100, (k == 3));
            lit("t3_dec14", 2, base, k, 100, (k == 3));
        end
        j0 = cap_at(1, base, 0);
        j3 = cap_at(1, base, 3);
        if (j0 >= 0 && j3 >= 0) chk("t3_span16", 1, 64'(cap[j3].cyc_no - cap[j0].cyc_no), 64'd12);
        j0 = cap_at(2, base, 0);
        j3 = cap_at(2, base, 3);
        if (j0 >= 0 && j3 >= 0) chk("t3_span14", 2, 64'(cap[j3].cyc_no - cap[j0].cyc_no), 64'd10);

        // Gapped input: same values, each output one edge after its sample's.
        base = cap.size();
        a3   = 0;
        do_start();
        for (int k = 0; k < 8; k++) begin
            send(t1_vals[k]);
            if (k == 3) a3 = cyc;
            idle(2);
        end
        idle(4);
        lit("t4_avg0", 0, base, 0, 6, 1'b0);
        lit("t4_avg1", 0, base, 1, 5, 1'b0);
        lit("t4_avg2", 0, base, 2, 4, 1'b0);
        lit("t4_avg3", 0, base, 3, 2, 1'b0);
        lit("t4_avg4", 0, base, 4, 0, 1'b1);
        j0 = cap_at(0, base, 0);
        j1 = cap_at(0, base, 1);
        if (j0 >= 0) chk("t4_latency", 0, 64'(cap[j0].cyc_no), 64'(a3 + 1));
        if (j0 >= 0 && j1 >= 0) chk("t4_spacing", 0, 64'(cap[j1].cyc_no - cap[j0].cyc_no), 64'd3);

        // Restart mid-RUN with continuous input; restart-cycle sample is dropped.
        do_start();
        repeat (6) send(100);
        start     = 1'b1;
        in_valid  = 1'b1;
        in_sample = 20'sd7;
        tick();
        start  = 1'b0;
        s_edge = cyc;
        base   = cap.size();
        repeat (8) send(8);
        idle(4);
        chk("t5_count", 0, 64'(cap_n(0, base)), 64'd5);
        j0 = cap_at(0, base, 0);
        if (j0 >= 0) chk("t5_first_edge", 0, 64'(cap[j0].cyc_no), 64'(s_edge + 5));
        lit("t5_refill0", 0, base, 0, 8, 1'b0);
        lit("t5_refill4", 0, base, 4, 8, 1'b1);

        // Reset with samples in flight, then input while idle.
        do_start();
        repeat (5) send(40);
        reset    = 1'b1;
        in_valid = 1'b1;
        tick();
        reset = 1'b0;
        base  = cap.size();
        repeat (6) send(55);
        idle(3);
        for (int i = 0; i < NI; i++) begin
            chk("t6_no_output", i, 64'(cap_n(i, base)), 64'd0);
            chk("t6_busy", i, 64'(dbusy[i]), 64'd0);
            chk("t6_out", i, 64'(dout[i]), 64'd0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
